// File: rtl/dmem_arbiter.sv
// N-channel arbiter in front of one single-port synchronous data RAM.
// Zero-latency combinational grant, one-cycle registered read return.
module dmem_arbiter #(
   parameter int NUM_CH   = 3,
   parameter int ADDR_W   = 12,
   parameter int DATA_W   = 32,
   parameter int CPU_PRIO = 1,
   parameter int MAX_WAIT = 15
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [NUM_CH-1:0]          req,
   input  logic [NUM_CH-1:0]          we,
   input  logic [NUM_CH*ADDR_W-1:0]   addr,
   input  logic [NUM_CH*DATA_W-1:0]   wdata,
   output logic [NUM_CH-1:0]          gnt,
   output logic [NUM_CH-1:0]          rvalid,
   output logic [DATA_W-1:0]          rdata,
   output logic                       mem_wEn,
   output logic [ADDR_W-1:0]          mem_addr,
   output logic [DATA_W-1:0]          mem_dataIn,
   input  logic [DATA_W-1:0]          mem_dataOut
);

   localparam int PTR_W = $clog2(NUM_CH);
   localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

   logic [PTR_W-1:0]      ptr_reg;
   logic [PTR_W-1:0]      owner_reg;
   logic                  rd_pend_reg;
   logic [7:0]            wcnt_reg [1:NUM_CH-1];

   logic [NUM_CH-1:0]     forced;
   logic [PTR_W-1:0]      hi_base;
   logic [2*NUM_CH-1:0]   rr_all;
   logic [2*NUM_CH-3:0]   rr_hi;
   logic                  win_valid;
   logic [PTR_W-1:0]      win_idx;
   logic [PTR_W-1:0]      ptr_next;
   logic                  xfer;
   logic                  rd_fire;

   // In priority mode the round-robin only spans channels 1..NUM_CH-1,
   // so a pointer of 0 behaves like 1 (base offset 0 within that group).
   assign hi_base = (ptr_reg == '0) ? '0 : ptr_reg - 1'b1;

   assign forced[0] = 1'b0;

   genvar gi;
   generate
      for (gi = 1; gi < NUM_CH; gi++) begin : g_wait
         assign forced[gi] = req[gi] && (wcnt_reg[gi] >= MAX_WAIT_C);

         always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
               wcnt_reg[gi] <= 8'd0;
            end else if (!req[gi] || gnt[gi]) begin
               wcnt_reg[gi] <= 8'd0;
            end else if (wcnt_reg[gi] != 8'hFF) begin
               wcnt_reg[gi] <= wcnt_reg[gi] + 8'd1;
            end
         end
      end
   endgenerate

   always_comb begin
      int tmp;
      tmp       = 0;
      win_valid = 1'b0;
      win_idx   = '0;
      rr_all    = {req, req} >> ptr_reg;
      rr_hi     = {req[NUM_CH-1:1], req[NUM_CH-1:1]} >> hi_base;
      if (CPU_PRIO != 0) begin
         if (|forced) begin
            // Scan downward so the lowest forced index is the last one written.
            for (int i = NUM_CH - 1; i >= 1; i--) begin
               if (forced[i]) begin
                  win_idx = PTR_W'(i);
               end
            end
            win_valid = 1'b1;
         end else if (req[0]) begin
            win_valid = 1'b1;
            win_idx   = '0;
         end else begin
            for (int j = NUM_CH - 2; j >= 0; j--) begin
               if (rr_hi[j]) begin
                  tmp = int'(hi_base) + j;
                  if (tmp >= NUM_CH - 1) begin
                     tmp = tmp - (NUM_CH - 1);
                  end
                  win_idx   = PTR_W'(tmp + 1);
                  win_valid = 1'b1;
               end
            end
         end
      end else begin
         for (int j = NUM_CH - 1; j >= 0; j--) begin
            if (rr_all[j]) begin
               tmp = int'(ptr_reg) + j;
               if (tmp >= NUM_CH) begin
                  tmp = tmp - NUM_CH;
               end
               win_idx   = PTR_W'(tmp);
               win_valid = 1'b1;
            end
         end
      end
   end

   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_gnt
         // Reset low blanks the grant immediately, without waiting for a clock.
         assign gnt[gi]    = reset && win_valid && (win_idx == PTR_W'(gi));
         assign rvalid[gi] = rd_pend_reg && (owner_reg == PTR_W'(gi));
      end
   endgenerate

   always_comb begin
      mem_addr   = '0;
      mem_dataIn = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (gnt[i]) begin
            mem_addr   = addr[i*ADDR_W +: ADDR_W];
            mem_dataIn = wdata[i*DATA_W +: DATA_W];
         end
      end
   end

   assign mem_wEn  = |(we & gnt);
   assign xfer     = |gnt;
   assign rd_fire  = |(gnt & ~we);
   assign ptr_next = (win_idx == PTR_W'(NUM_CH - 1)) ? '0 : win_idx + 1'b1;
   assign rdata    = mem_dataOut;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ptr_reg     <= '0;
         owner_reg   <= '0;
         rd_pend_reg <= 1'b0;
      end else begin
         if (xfer) begin
            ptr_reg <= ptr_next;
         end
         rd_pend_reg <= rd_fire;
         if (rd_fire) begin
            owner_reg <= win_idx;
         end
      end
   end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Parametrised N-channel data-memory arbiter between the processor's data port and additional bus masters (FFT engines, DMA) on one single-port synchronous RAM. It replaces the direct processor-to-RAM hookup in the top level. Each master gets a request/grant/read-valid handshake. Arbitration is round-robin, or processor-priority with a starvation guard.

## Interface
- NUM_CH, 3: number of master channels; channel 0 is the processor; legal range 2..8
- ADDR_W, 12: word address width
- DATA_W, 32: data width
- CPU_PRIO, 1: 1 = channel 0 has fixed priority with starvation guard; 0 = pure round-robin
- MAX_WAIT, 15: consecutive lost cycles after which a waiting channel is force-granted (CPU_PRIO=1 only); legal range 1..255
- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- req  in  NUM_CH  per-channel request
- we  in  NUM_CH  per-channel write enable, qualified by req
- addr  in  NUM_CH*ADDR_W  per-channel address; channel i occupies bits [i*ADDR_W +: ADDR_W]
- wdata  in  NUM_CH*DATA_W  per-channel write data, packed the same way
- gnt  out  NUM_CH  one-hot or zero; combinational grant
- rvalid  out  NUM_CH  one-hot or zero; read data valid, registered
- rdata  out  DATA_W  read data, shared by all channels; meaningful only with rvalid
- mem_wEn  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM address
- mem_dataIn  out  DATA_W  RAM write data
- mem_dataOut  in  DATA_W  RAM read data, valid one cycle after the address edge

## Operation
- A transfer occurs on a rising edge where req[i] & gnt[i] is true. A master holds req, we, addr and wdata stable until it sees gnt. It may drop req or present a new request in the cycle after the transfer.
- gnt is a function of req, the rotation pointer `ptr` and the wait counters. At most one bit is set. gnt is zero whenever req is zero.
- Round-robin: the winner is the first requesting channel scanning `ptr, ptr+1, ... NUM_CH-1, 0, ...`. On a transfer by channel k, `ptr <= (k+1) mod NUM_CH`. `ptr` is unchanged when there is no transfer.
- CPU_PRIO=1:
  - Priority order is forced channel first, then channel 0, then round-robin among channels 1..NUM_CH-1. The round-robin uses `ptr`, and a `ptr` of 0 is treated as 1.
  - Each channel i≥1 has a wait counter `wcnt[i]` (8 bit). It increments when req[i] & ~gnt[i], saturating at 255. It clears when gnt[i] or ~req[i].
  - A channel with `wcnt >= MAX_WAIT` is forced. If several channels are forced, the lowest index wins.
- Mux: mem_addr, mem_dataIn and mem_wEn come from the granted channel; `mem_wEn = we[k] & gnt[k]`. With no grant, mem_wEn=0, mem_addr=0 and mem_dataIn=0.
- Read return: on a read transfer by channel k, the owner register latches k. rvalid[k] is asserted in the next cycle and `rdata = mem_dataOut` in that cycle. Writes never raise rvalid.
- Reads may be granted back-to-back; each read gets its own rvalid in the next cycle. A write in the cycle after a read does not disturb that read's return.

## Timing
- Grant latency: 0 cycles. gnt is valid in the same cycle as req, when uncontested.
- Read latency: 1 cycle, from the transfer edge to rvalid/rdata.
- Throughput: one transfer per cycle total.
- Reset (reset=0) has immediate effect and no clock edge is needed:
  - ptr=0, owner=0, rvalid=0, all wcnt=0.
  - gnt is forced to 0, so mem_wEn=0.
- Reset assertion mid-read drops the pending rvalid.
- Release from reset is synchronous in effect; the first grant is possible in the first cycle with reset=1.
- Simultaneous requests from all channels, CPU_PRIO=0: grants rotate 0,1,2,0,... with a period of NUM_CH cycles.

## Test plan
- Reset: hold reset=0 with req=3'b111 -> gnt=0, rvalid=0, mem_wEn=0. On release, CPU_PRIO=0 grants channel 0 first.
- Single-channel write then read: ch1 writes 0xDEADBEEF to 0x01A, then reads 0x01A. Required response:
  - mem_wEn=1 only in the write cycle.
  - rvalid=3'b010 with rdata=0xDEADBEEF exactly one cycle after the read grant.
- Round-robin fairness, CPU_PRIO=0, NUM_CH=3: all channels hold req for 9 cycles -> gnt sequence 001,010,100 repeated three times; each channel makes 3 transfers.
- Priority with starvation guard, CPU_PRIO=1, MAX_WAIT=4: ch0 and ch2 request continuously. Required response:
  - ch0 is granted for 4 cycles.
  - ch2 is force-granted on the 5th cycle.
  - ch2's wcnt then clears and ch0 resumes.
- Back-to-back reads: ch0 reads 0x000, 0x001 and 0x002 on consecutive cycles (RAM preloaded with 0x11, 0x22, 0x33) -> rvalid[0] high for 3 consecutive cycles with rdata 0x11, 0x22, 0x33.
- Reset mid-read: assert reset in the cycle after a read grant -> rvalid stays 0. After release, state matches the reset values.
